// File: rtl/ddr3_cmd_sched.sv
// rtl/ddr3_cmd_sched.sv - closed-page DDR3 command scheduler
// Issues ACT -> RD/WR -> PRE per request and periodic REF after init.
module ddr3_cmd_sched #(
    parameter int T_RCD   = 6,
    parameter int T_RDPRE = 9,
    parameter int T_WRPRE = 18,
    parameter int T_RP    = 6,
    parameter int T_RFC   = 88,
    parameter int T_REFI  = 3120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [26:0] req_addr,
    output logic        req_ready,
    output logic [2:0]  cmd,
    output logic [2:0]  ba,
    output logic [13:0] addr,
    output logic        rd_issue,
    output logic        wr_issue,
    output logic        ref_err
);

    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam logic [7:0]  LD_RCD   = 8'(T_RCD - 1);
    localparam logic [7:0]  LD_RDPRE = 8'(T_RDPRE - 1);
    localparam logic [7:0]  LD_WRPRE = 8'(T_WRPRE - 1);
    localparam logic [7:0]  LD_RP    = 8'(T_RP - 1);
    localparam logic [7:0]  LD_RFC   = 8'(T_RFC - 1);
    localparam logic [15:0] LD_REFI  = 16'(T_REFI - 1);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ACT_WAIT,
        S_RW_WAIT,
        S_PRE_WAIT,
        S_REF_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] refi_q, refi_d;
    logic        ref_pending_q, ref_pending_d;
    logic        ref_err_q, ref_err_d;
    logic        we_q, we_d;
    logic [13:0] row_q, row_d;
    logic [2:0]  bank_q, bank_d;
    logic [9:0]  col_q, col_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [2:0]  ba_q, ba_d;
    logic [13:0] addr_q, addr_d;
    logic        rd_issue_q, rd_issue_d;
    logic        wr_issue_q, wr_issue_d;
    logic        wait_zero;

    assign wait_zero = (wait_q == 8'd0);
    assign req_ready = (state_q == S_IDLE) && !ref_pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_INIT: if (init_done) state_d = S_IDLE;
            S_IDLE: begin
                if (ref_pending_q)  state_d = S_REF_WAIT;
                else if (req_valid) state_d = S_ACT_WAIT;
            end
            S_ACT_WAIT: if (wait_zero) state_d = S_RW_WAIT;
            S_RW_WAIT:  if (wait_zero) state_d = S_PRE_WAIT;
            S_PRE_WAIT: if (wait_zero) state_d = S_IDLE;
            S_REF_WAIT: if (wait_zero) state_d = S_IDLE;
            default:    state_d = S_WAIT_INIT;
        endcase
    end

    always_comb begin
        cmd_d         = CMD_NOP;
        ba_d          = ba_q;
        addr_d        = addr_q;
        rd_issue_d    = 1'b0;
        wr_issue_d    = 1'b0;
        wait_d        = wait_zero ? 8'd0 : wait_q - 8'd1;
        we_d          = we_q;
        row_d         = row_q;
        bank_d        = bank_q;
        col_d         = col_q;
        ref_pending_d = ref_pending_q;
        ref_err_d     = ref_err_q;
        refi_d        = refi_q;

        case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    cmd_d         = CMD_REF;
                    ref_pending_d = 1'b0;
                    wait_d        = LD_RFC;
                end else if (req_valid) begin
                    we_d   = req_we;
                    row_d  = req_addr[26:13];
                    bank_d = req_addr[12:10];
                    col_d  = req_addr[9:0];
                    cmd_d  = CMD_ACT;
                    ba_d   = req_addr[12:10];
                    addr_d = req_addr[26:13];
                    wait_d = LD_RCD;
                end
            end
            S_ACT_WAIT: begin
                if (wait_zero) begin
                    // A10 low: no auto-precharge, the explicit PRE closes the row
                    cmd_d      = we_q ? CMD_WR : CMD_RD;
                    ba_d       = bank_q;
                    addr_d     = {4'b0000, col_q};
                    rd_issue_d = !we_q;
                    wr_issue_d = we_q;
                    wait_d     = we_q ? LD_WRPRE : LD_RDPRE;
                end
            end
            S_RW_WAIT: begin
                if (wait_zero) begin
                    cmd_d  = CMD_PRE;
                    ba_d   = bank_q;
                    addr_d = {4'b0000, col_q};
                    wait_d = LD_RP;
                end
            end
            default: ;
        endcase

        // A fresh expiry overrides the clear from a REF issued this same cycle
        if (state_q == S_WAIT_INIT) begin
            if (init_done) refi_d = LD_REFI;
        end else if (refi_q == 16'd0) begin
            refi_d        = LD_REFI;
            ref_pending_d = 1'b1;
            if (ref_pending_q) ref_err_d = 1'b1;
        end else begin
            refi_d = refi_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q        <= 8'd0;
            refi_q        <= 16'd0;
            ref_pending_q <= 1'b0;
            ref_err_q     <= 1'b0;
            we_q          <= 1'b0;
            row_q         <= 14'd0;
            bank_q        <= 3'd0;
            col_q         <= 10'd0;
            cmd_q         <= CMD_NOP;
            ba_q          <= 3'd0;
            addr_q        <= 14'd0;
            rd_issue_q    <= 1'b0;
            wr_issue_q    <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            refi_q        <= refi_d;
            ref_pending_q <= ref_pending_d;
            ref_err_q     <= ref_err_d;
            we_q          <= we_d;
            row_q         <= row_d;
            bank_q        <= bank_d;
            col_q         <= col_d;
            cmd_q         <= cmd_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            rd_issue_q    <= rd_issue_d;
            wr_issue_q    <= wr_issue_d;
        end
    end

    assign cmd      = cmd_q;
    assign ba       = ba_q;
    assign addr     = addr_q;
    assign rd_issue = rd_issue_q;
    assign wr_issue = wr_issue_q;
    assign ref_err  = ref_err_q;

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// tb/tb_ddr3_cmd_sched.sv - directed bench for ddr3_cmd_sched
// Main instance uses T_REFI=150; a second instance (T_REFI=20, T_RFC=30) exercises refresh overrun.
module tb_ddr3_cmd_sched;

    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [26:0] req_addr = 27'd0;

    logic        req_ready, rd_issue, wr_issue, ref_err;
    logic [2:0]  cmd, ba;
    logic [13:0] addr;

    logic        o_req_valid = 1'b0;
    logic        o_req_we = 1'b0;
    logic [26:0] o_req_addr = 27'd0;
    logic        o_req_ready, o_rd_issue, o_wr_issue, o_ref_err;
    logic [2:0]  o_cmd, o_ba;
    logic [13:0] o_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] exp_cmd [0:400];
    logic       exp_rd  [0:400];
    logic       exp_wr  [0:400];

    ddr3_cmd_sched #(.T_REFI(150)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_ready(req_ready), .cmd(cmd), .ba(ba), .addr(addr),
        .rd_issue(rd_issue), .wr_issue(wr_issue), .ref_err(ref_err)
    );

    ddr3_cmd_sched #(.T_REFI(20), .T_RFC(30)) dut_ovr (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(o_req_valid), .req_we(o_req_we), .req_addr(o_req_addr),
        .req_ready(o_req_ready), .cmd(o_cmd), .ba(o_ba), .addr(o_addr),
        .rd_issue(o_rd_issue), .wr_issue(o_wr_issue), .ref_err(o_ref_err)
    );

    always #5 clk = ~clk;

    task automatic clear_exp();
        for (int i = 0; i <= 400; i++) begin
            exp_cmd[i] = C_NOP;
            exp_rd[i]  = 1'b0;
            exp_wr[i]  = 1'b0;
        end
    endtask

    // ACT at t, RD/WR at t+6, PRE at t+6+xpre
    task automatic add_access(input int t, input bit we, input int xpre);
        exp_cmd[t]          = C_ACT;
        exp_cmd[t+6]        = we ? C_WR : C_RD;
        exp_rd[t+6]         = !we;
        exp_wr[t+6]         = we;
        exp_cmd[t+6+xpre]   = C_PRE;
    endtask

    // Returns at the negedge just after the edge that moves the DUT into IDLE (offset 0)
    task automatic reset_and_init();
        @(negedge clk);
        rst = 1'b1; init_done = 1'b0; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; init_done = 1'b0; req_valid = 1'b0;
        for (int k = 0; k < 53; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b0;
            vectors++;
            if (cmd !== C_NOP || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_wait@%0d: cmd=%b ready=%b, want cmd=111 ready=0", k, cmd, req_ready);
            end
        end
        vectors++;
        if (ba !== 3'd0 || addr !== 14'd0 || rd_issue !== 1'b0 || wr_issue !== 1'b0 || ref_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vals: ba=%h addr=%h rd=%b wr=%b err=%b, want all 0", ba, addr, rd_issue, wr_issue, ref_err);
        end
        init_done = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL init_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_single(input bit we);
        int xpre;
        int last;
        xpre = we ? 18 : 9;
        last = 1 + 6 + xpre + 6;
        reset_and_init();
        clear_exp();
        add_access(1, we, xpre);
        req_valid = 1'b1; req_we = we;
        req_addr  = {14'h1A5, 3'd3, 10'h03C};
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            vectors++;
            if (cmd !== exp_cmd[k] || rd_issue !== exp_rd[k] || wr_issue !== exp_wr[k]) begin
                miscompares++;
                $display("FAIL single_cmd@%0d: cmd=%b rd=%b wr=%b, want cmd=%b rd=%b wr=%b",
                         k, cmd, rd_issue, wr_issue, exp_cmd[k], exp_rd[k], exp_wr[k]);
            end
            vectors++;
            if (req_ready !== (k == last)) begin
                miscompares++;
                $display("FAIL single_ready@%0d: got %b expected %b", k, req_ready, (k == last));
            end
            if (k == 1 || k == 7) begin
                vectors++;
                if (ba !== 3'd3 || addr !== ((k == 1) ? 14'h01A5 : 14'h003C)) begin
                    miscompares++;
                    $display("FAIL single_addr@%0d: ba=%h addr=%h", k, ba, addr);
                end
            end
            if (k == 7 + xpre) begin
                vectors++;
                if (ba !== 3'd3 || addr[10] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_pre_addr: ba=%h a10=%b, want ba=3 a10=0", ba, addr[10]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_and_init();
        clear_exp();
        add_access(1, 1'b0, 9);
        add_access(23, 1'b0, 9);
        req_valid = 1'b1; req_we = 1'b0;
        req_addr  = {14'h1A5, 3'd3, 10'h03C};
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            if (k == 1)  req_addr  = {14'h2222, 3'd5, 10'h155};
            if (k == 23) req_valid = 1'b0;
            vectors++;
            if (cmd !== exp_cmd[k] || rd_issue !== exp_rd[k]) begin
                miscompares++;
                $display("FAIL b2b_cmd@%0d: cmd=%b rd=%b, want cmd=%b rd=%b", k, cmd, rd_issue, exp_cmd[k], exp_rd[k]);
            end
            if (k == 23 || k == 29) begin
                vectors++;
                if (ba !== 3'd5 || addr !== ((k == 23) ? 14'h2222 : 14'h0155)) begin
                    miscompares++;
                    $display("FAIL b2b_addr@%0d: ba=%h addr=%h", k, ba, addr);
                end
            end
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready_end: got %b expected 1", req_ready);
        end
    endtask

    // Refresh expires at offset 150 mid-access; REF slips to 155, next ACT at 155+89
    task automatic test_refresh_priority();
        reset_and_init();
        clear_exp();
        for (int n = 0; n < 7; n++) add_access(1 + 22*n, 1'b0, 9);
        exp_cmd[155] = C_REF;
        add_access(244, 1'b0, 9);
        add_access(266, 1'b0, 9);
        add_access(288, 1'b0, 9);
        exp_cmd[310] = C_REF;
        req_valid = 1'b1; req_we = 1'b0;
        req_addr  = {14'h0777, 3'd1, 10'h00F};
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            vectors++;
            if (cmd !== exp_cmd[k] || rd_issue !== exp_rd[k]) begin
                miscompares++;
                $display("FAIL refresh_cmd@%0d: cmd=%b rd=%b, want cmd=%b rd=%b", k, cmd, rd_issue, exp_cmd[k], exp_rd[k]);
            end
        end
        req_valid = 1'b0;
        vectors++;
        if (ref_err !== 1'b0) begin
            miscompares++;
            $display("FAIL refresh_err: got %b expected 0", ref_err);
        end
    endtask

    // Small instance: REF at 21 and 52; pending set at 60 is still set at 80 -> ref_err
    task automatic test_refresh_overrun();
        reset_and_init();
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (k == 20 || k == 21 || k == 52) begin
                vectors++;
                if (o_cmd !== ((k == 20) ? C_NOP : C_REF)) begin
                    miscompares++;
                    $display("FAIL ovr_cmd@%0d: got %b expected %b", k, o_cmd, (k == 20) ? C_NOP : C_REF);
                end
            end
            if (k == 21) begin
                vectors++;
                if (o_req_ready !== 1'b0 || o_rd_issue !== 1'b0 || o_wr_issue !== 1'b0 || o_ba !== 3'd0 || o_addr !== 14'd0) begin
                    miscompares++;
                    $display("FAIL ovr_side@21: ready=%b rd=%b wr=%b ba=%h addr=%h, want all 0",
                             o_req_ready, o_rd_issue, o_wr_issue, o_ba, o_addr);
                end
            end
            if (k == 79 || k == 80 || k == 160) begin
                vectors++;
                if (o_ref_err !== (k != 79)) begin
                    miscompares++;
                    $display("FAIL ovr_err@%0d: got %b expected %b", k, o_ref_err, (k != 79));
                end
            end
        end
        vectors++;
        if (ref_err !== 1'b0) begin
            miscompares++;
            $display("FAIL main_err_quiet: got %b expected 0", ref_err);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (o_ref_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_err_cleared: got %b expected 0", o_ref_err);
        end
    endtask

    task automatic test_reset_mid_access();
        reset_and_init();
        req_valid = 1'b1; req_we = 1'b0;
        req_addr  = {14'h1A5, 3'd3, 10'h03C};
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (cmd !== C_ACT) begin
            miscompares++;
            $display("FAIL mid_act: got %b expected %b", cmd, C_ACT);
        end
        @(negedge clk);
        rst = 1'b1; init_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (cmd !== C_NOP || req_ready !== 1'b0 || ba !== 3'd0 || addr !== 14'd0) begin
            miscompares++;
            $display("FAIL mid_reset: cmd=%b ready=%b ba=%h addr=%h, want 111/0/0/0", cmd, req_ready, ba, addr);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if (cmd !== C_NOP || req_ready !== 1'b0 || rd_issue !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_wait@%0d: cmd=%b ready=%b rd=%b, want 111/0/0", k, cmd, req_ready, rd_issue);
            end
        end
        init_done = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reinit_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (cmd !== C_ACT || ba !== 3'd3 || addr !== 14'h01A5) begin
            miscompares++;
            $display("FAIL mid_reinit_act: cmd=%b ba=%h addr=%h", cmd, ba, addr);
        end
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_back_to_back();
        test_refresh_priority();
        test_refresh_overrun();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
